// File: rtl/recon_pkg.sv
// recon_pkg: shared types and defaults for the reconvergent-stage feeder.
// Holds VEC_W, RECON_LAT and the {a,b,c,d,e} operand struct.
package recon_pkg;

  localparam int VEC_W     = 5;
  localparam int RECON_LAT = 2;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
  } recon_vec_t;

endpackage

// File: rtl/recon_fifo.sv
// recon_fifo: plain sync FIFO, no handshake (caller gates push/pop).
// Ports: clk, rst, push, din, pop, head, count.
module recon_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign head = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

endmodule

// File: rtl/recon_feeder.sv
// recon_feeder: buffers operand vectors, issues them on a..e, tags results.
// Ports: in_* handshake, issue_en, a..e, x_in, out_*, count, res_cnt.
// RECON_FEEDER_HOLD_EN: a..e hold last issue instead of returning to 0.
module recon_feeder
  import recon_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = RECON_LAT,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [VEC_W-1:0]           in_vec,
  input  logic                       issue_en,
  output logic                       a,
  output logic                       b,
  output logic                       c,
  output logic                       d,
  output logic                       e,
  input  logic                       x_in,
  output logic                       out_valid,
  output logic                       out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           res_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  logic       push;
  logic       pop;
  recon_vec_t head;
  recon_vec_t opnd;
  logic [LAT-1:0] issue_v;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = issue_en && (count != '0);

  recon_fifo #(
    .DEPTH (DEPTH),
    .W     (VEC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_vec),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd <= '0;
`ifdef RECON_FEEDER_HOLD_EN
    end else if (pop) begin
      opnd <= head;
`else
    end else begin
      opnd <= pop ? head : '0;
`endif
    end
  end

  assign {a, b, c, d, e} = opnd;

  // issue_v[0] marks the edge a..e change; out_valid is the register
  // aligned with the stage's output register, LAT edges after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_v   <= '0;
      out_valid <= 1'b0;
    end else begin
      issue_v[0] <= pop;
      for (int i = 1; i < LAT; i++) issue_v[i] <= issue_v[i-1];
      out_valid <= issue_v[LAT-1];
    end
  end

  assign out_data = x_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt <= '0;
    end else if (out_valid && (res_cnt != '1)) begin
      res_cnt <= res_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_recon_feeder.sv
// tb_recon_feeder: random + directed stimulus against a queue-based model.
// Includes a 2-register stage model driving x_in = xnor-reduce(a..e).
module tb_recon_feeder;
  import recon_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_vec;
  logic       issue_en;
  logic       a, b, c, d, e;
  logic       x_in = 1'b0;
  logic       out_valid;
  logic       out_data;
  logic [2:0] count;
  logic [15:0] res_cnt;

  logic       in_ready2;
  logic       a2, b2, c2, d2, e2;
  logic       ov2, od2;
  logic [2:0] count2;
  logic [1:0] res2;

  logic       s1 = 1'b0;

  always #5 clk = ~clk;

  recon_feeder #(.DEPTH(DEPTH), .LAT(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .issue_en(issue_en),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .x_in(x_in), .out_valid(out_valid), .out_data(out_data),
    .count(count), .res_cnt(res_cnt)
  );

  recon_feeder #(.DEPTH(DEPTH), .LAT(LAT), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2), .in_vec(in_vec),
    .issue_en(issue_en),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2),
    .x_in(x_in), .out_valid(ov2), .out_data(od2),
    .count(count2), .res_cnt(res2)
  );

  always @(posedge clk) begin
    s1   <= ~^{a, b, c, d, e};
    x_in <= s1;
  end

  int checks = 0;
  int fails  = 0;

  logic [4:0] q[$];
  bit         ov_at[int];
  bit         dat_at[int];
  logic [4:0] mvec;
  bit         mov;
  int         rcnt;
  int         rcnt2;
  int         cyc;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    ov_at.delete();
    dat_at.delete();
    mvec  = '0;
    mov   = 1'b0;
    rcnt  = 0;
    rcnt2 = 0;
  endtask

  task automatic model_edge();
    bit full;
    logic [4:0] v;
    if (mov) begin
      if (rcnt < 65535) rcnt++;
      if (rcnt2 < 3) rcnt2++;
    end
    full = (q.size() == DEPTH);
    if (issue_en && q.size() != 0) begin
      v = q.pop_front();
      mvec = v;
      ov_at[cyc+LAT]  = 1'b1;
      dat_at[cyc+LAT] = ~^v;
    end else begin
`ifndef RECON_FEEDER_HOLD_EN
      mvec = '0;
`endif
    end
    if (in_valid && !full) q.push_back(in_vec);
    mov = ov_at.exists(cyc);
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    check("abcde", 32'({a, b, c, d, e}), 32'(mvec));
    check("out_valid", 32'(out_valid), 32'(mov));
    if (mov) check("out_data", 32'(out_data), 32'(dat_at[cyc]));
    check("res_cnt", 32'(res_cnt), 32'(rcnt));
    check("res_cnt_w2", 32'(res2), 32'(rcnt2));
    check("out_valid_w2", 32'(ov2), 32'(mov));
  endtask

  task automatic step(input bit iv, input logic [4:0] v, input bit ie);
    in_valid = iv;
    in_vec   = v;
    issue_en = ie;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_clear();
    check_all();
    in_valid = 1'b0;
    issue_en = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    cyc      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_vec   = '0;
    issue_en = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    step(1'b1, 5'b11001, 1'b1);
    repeat (5) step(1'b0, 5'b0, 1'b1);

    step(1'b1, 5'b11110, 1'b1);
    step(1'b1, 5'b00000, 1'b1);
    repeat (5) step(1'b0, 5'b0, 1'b1);

    for (int i = 0; i < 5; i++) step(1'b1, 5'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 5'($urandom), 1'b1);
    repeat (8) step(1'b0, 5'b0, 1'b1);

    step(1'b1, 5'b10101, 1'b1);
    repeat (5) step(1'b0, 5'b0, 1'b0);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 99) < 60, 5'($urandom),
           $urandom_range(0, 99) < 50);

    repeat (6) step(1'b0, 5'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 5'($urandom), 1'b0);
    step(1'b1, 5'($urandom), 1'b1);
    step(1'b1, 5'($urandom), 1'b1);
    do_reset();
    repeat (4) step(1'b0, 5'b0, 1'b0);
    repeat (4) step(1'b0, 5'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
